mgr_array_stu_mux: RTL and testbench

- Parametrised N-to-1 aggregator for manager upstream traffic in the manager array.
- Each manager instance drives one upstream channel (valid/cntl/type/data/oob_data, ready back) into a per-channel FIFO.
- A packet-atomic round-robin arbiter merges the channels onto the single system stack upstream bus and tags each beat with the source manager ID.
- Next-generation replacement for the hard-wired per-manager upstream connectivity; adds buffering, fairness, ID tagging and protocol-error detection.

---
 rtl/mgr_array_stu_mux_pkg.sv | 38 +++
 rtl/mgr_stu_chan_fifo.sv | 58 +++++
 rtl/mgr_array_stu_mux.sv | 202 ++++++++++++++++++++
 tb/tb_mgr_array_stu_mux.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgr_array_stu_mux_pkg.sv
// Shared definitions for the manager-array upstream aggregator: cntl encodings,
// arbiter state encoding and the bit layout of a buffered upstream beat.
package mgr_array_stu_mux_pkg;

    localparam int CNTL_W = 2;

    localparam logic [CNTL_W-1:0] CNTL_MOM     = 2'b00;
    localparam logic [CNTL_W-1:0] CNTL_SOM     = 2'b01;
    localparam logic [CNTL_W-1:0] CNTL_EOM     = 2'b10;
    localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Entry layout, MSB to LSB: {cntl, type, data, oob}.
    function automatic int entry_w(int type_w, int data_w, int oob_w);
        return CNTL_W + type_w + data_w + oob_w;
    endfunction

    function automatic int data_lsb(int oob_w);
        return oob_w;
    endfunction

    function automatic int type_lsb(int data_w, int oob_w);
        return data_w + oob_w;
    endfunction

    function automatic int cntl_lsb(int type_w, int data_w, int oob_w);
        return type_w + data_w + oob_w;
    endfunction

    function automatic logic is_som(logic [CNTL_W-1:0] c);
        return (c == CNTL_SOM) || (c == CNTL_SOM_EOM);
    endfunction

endpackage

// File: rtl/mgr_stu_chan_fifo.sv
// Per-channel synchronous FIFO with occupancy count, empty/full flags and a
// combinational peek at the head entry.
module mgr_stu_chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mgr_array_stu_mux.sv
// N-to-1 upstream aggregator: per-manager FIFOs merged onto one system-stack bus
// by a packet-atomic round-robin arbiter that tags each beat with its source ID.
module mgr_array_stu_mux
    import mgr_array_stu_mux_pkg::*;
#(
    parameter int NUM_MGR    = 4,
    parameter int DATA_W     = 64,
    parameter int TYPE_W     = 2,
    parameter int OOB_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = $clog2(NUM_MGR)
) (
    input  logic                        clk,
    input  logic                        reset_poweron,
    input  logic [NUM_MGR-1:0]          mgr__mux__valid,
    input  logic [2*NUM_MGR-1:0]        mgr__mux__cntl,
    input  logic [TYPE_W*NUM_MGR-1:0]   mgr__mux__type,
    input  logic [DATA_W*NUM_MGR-1:0]   mgr__mux__data,
    input  logic [OOB_W*NUM_MGR-1:0]    mgr__mux__oob_data,
    output logic [NUM_MGR-1:0]          mux__mgr__ready,
    output logic                        mux__stu__valid,
    output logic [1:0]                  mux__stu__cntl,
    output logic [TYPE_W-1:0]           mux__stu__type,
    output logic [DATA_W-1:0]           mux__stu__data,
    output logic [OOB_W-1:0]            mux__stu__oob_data,
    output logic [ID_W-1:0]             mux__stu__mgrId,
    input  logic                        stu__mux__ready,
    output logic [NUM_MGR-1:0]          mux__sys__proto_err
);

    localparam int ENTRY_W  = entry_w(TYPE_W, DATA_W, OOB_W);
    localparam int DATA_LSB = data_lsb(OOB_W);
    localparam int TYPE_LSB = type_lsb(DATA_W, OOB_W);
    localparam int CNTL_LSB = cntl_lsb(TYPE_W, DATA_W, OOB_W);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] head      [NUM_MGR];
    logic [CNTL_W-1:0]  head_cntl [NUM_MGR];
    logic [CNT_W-1:0]   count     [NUM_MGR];
    logic [NUM_MGR-1:0] empty, full, push, pop;

    for (genvar g = 0; g < NUM_MGR; g++) begin : g_chan
        // Ready comes from registered occupancy only; a pop in the same cycle is not credited.
        assign mux__mgr__ready[g] = (count[g] < DEPTH_CNT);
        assign push[g]            = mgr__mux__valid[g] && !full[g];
        assign head_cntl[g]       = head[g][CNTL_LSB +: CNTL_W];

        mgr_stu_chan_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk           (clk),
            .reset_poweron (reset_poweron),
            .push_i        (push[g]),
            .wdata_i       ({mgr__mux__cntl[2*g +: 2],
                             mgr__mux__type[TYPE_W*g +: TYPE_W],
                             mgr__mux__data[DATA_W*g +: DATA_W],
                             mgr__mux__oob_data[OOB_W*g +: OOB_W]}),
            .pop_i         (pop[g]),
            .head_o        (head[g]),
            .count_o       (count[g]),
            .empty_o       (empty[g]),
            .full_o        (full[g])
        );
    end

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [NUM_MGR-1:0] err_q, err_d;
    logic               valid_q, valid_d;
    logic [CNTL_W-1:0]  cntl_q, cntl_d;
    logic [TYPE_W-1:0]  type_q, type_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [OOB_W-1:0]   oob_q, oob_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic               load_ok, ld_en, found;
    logic [ID_W-1:0]    ld_sel, pick, idx;
    logic [CNTL_W-1:0]  ld_cntl;

    function automatic logic [ID_W-1:0] wrap_id(int v);
        return ID_W'(v % NUM_MGR);
    endfunction

    function automatic logic [ID_W-1:0] next_id(logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_MGR - 1)) ? '0 : id + 1'b1;
    endfunction

    assign load_ok = !valid_q || stu__mux__ready;

    // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        err_d   = err_q;
        pop     = '0;
        ld_en   = 1'b0;
        ld_sel  = grant_q;
        ld_cntl = CNTL_MOM;
        found   = 1'b0;
        pick    = '0;
        idx     = '0;

        // A MOM/EOM at a head that cannot belong to the active packet is a stray: drop it.
        for (int i = 0; i < NUM_MGR; i++) begin
            if (!empty[i] && !is_som(head_cntl[i]) &&
                (state_q == ST_IDLE || ID_W'(i) != grant_q)) begin
                pop[i]   = 1'b1;
                err_d[i] = 1'b1;
            end
        end

        if (state_q == ST_IDLE && load_ok) begin
            for (int k = 0; k < NUM_MGR; k++) begin
                idx = wrap_id(int'(rr_q) + k);
                if (!found && !empty[idx] && is_som(head_cntl[idx])) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
            if (found) begin
                pop[pick] = 1'b1;
                ld_en     = 1'b1;
                ld_sel    = pick;
                ld_cntl   = head_cntl[pick];
                grant_d   = pick;
                if (head_cntl[pick] == CNTL_SOM_EOM) rr_d = next_id(pick);
                else                                 state_d = ST_XFER;
            end
        end else if (state_q == ST_XFER && load_ok && !empty[grant_q]) begin
            pop[grant_q] = 1'b1;
            ld_en        = 1'b1;
            ld_sel       = grant_q;
            ld_cntl      = head_cntl[grant_q];
            if (head_cntl[grant_q] == CNTL_EOM) begin
                state_d = ST_IDLE;
                rr_d    = next_id(grant_q);
            end else if (is_som(head_cntl[grant_q])) begin
                // A new start inside a packet closes the open one with a forced EOM.
                err_d[grant_q] = 1'b1;
                ld_cntl        = CNTL_EOM;
                state_d        = ST_IDLE;
                rr_d           = next_id(grant_q);
            end
        end

        valid_d = valid_q;
        cntl_d  = cntl_q;
        type_d  = type_q;
        data_d  = data_q;
        oob_d   = oob_q;
        id_d    = id_q;
        if (load_ok) begin
            valid_d = ld_en;
            if (ld_en) begin
                cntl_d = ld_cntl;
                type_d = head[ld_sel][TYPE_LSB +: TYPE_W];
                data_d = head[ld_sel][DATA_LSB +: DATA_W];
                oob_d  = head[ld_sel][0 +: OOB_W];
                id_d   = ld_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            cntl_q  <= '0;
            type_q  <= '0;
            data_q  <= '0;
            oob_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            cntl_q  <= cntl_d;
            type_q  <= type_d;
            data_q  <= data_d;
            oob_q   <= oob_d;
            id_q    <= id_d;
        end
    end

    assign mux__stu__valid     = valid_q;
    assign mux__stu__cntl      = cntl_q;
    assign mux__stu__type      = type_q;
    assign mux__stu__data      = data_q;
    assign mux__stu__oob_data  = oob_q;
    assign mux__stu__mgrId     = id_q;
    assign mux__sys__proto_err = err_q;

endmodule

// File: tb/tb_mgr_array_stu_mux.sv
// Directed bench for mgr_array_stu_mux: per-channel beat queues feed the inputs,
// a monitor logs every delivered output beat for comparison against expectations.
module tb_mgr_array_stu_mux;

    localparam int NUM_MGR = 4;
    localparam int DATA_W  = 64;
    localparam int TYPE_W  = 2;
    localparam int OOB_W   = 32;
    localparam int ID_W    = 2;

    localparam logic [1:0] MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SOE = 2'b11;

    logic                      clk = 1'b0;
    logic                      reset_poweron;
    logic [NUM_MGR-1:0]        mgr_valid = '0;
    logic [2*NUM_MGR-1:0]      mgr_cntl  = '0;
    logic [TYPE_W*NUM_MGR-1:0] mgr_type  = '0;
    logic [DATA_W*NUM_MGR-1:0] mgr_data  = '0;
    logic [OOB_W*NUM_MGR-1:0]  mgr_oob   = '0;
    logic [NUM_MGR-1:0]        ready;
    logic                      stu_valid;
    logic [1:0]                stu_cntl;
    logic [TYPE_W-1:0]         stu_type;
    logic [DATA_W-1:0]         stu_data;
    logic [OOB_W-1:0]          stu_oob;
    logic [ID_W-1:0]           stu_id;
    logic                      stu_ready;
    logic [NUM_MGR-1:0]        proto_err;

    always #5 clk = ~clk;

    mgr_array_stu_mux #(
        .NUM_MGR(NUM_MGR), .DATA_W(DATA_W), .TYPE_W(TYPE_W), .OOB_W(OOB_W), .FIFO_DEPTH(4)
    ) dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .mgr__mux__valid     (mgr_valid),
        .mgr__mux__cntl      (mgr_cntl),
        .mgr__mux__type      (mgr_type),
        .mgr__mux__data      (mgr_data),
        .mgr__mux__oob_data  (mgr_oob),
        .mux__mgr__ready     (ready),
        .mux__stu__valid     (stu_valid),
        .mux__stu__cntl      (stu_cntl),
        .mux__stu__type      (stu_type),
        .mux__stu__data      (stu_data),
        .mux__stu__oob_data  (stu_oob),
        .mux__stu__mgrId     (stu_id),
        .stu__mux__ready     (stu_ready),
        .mux__sys__proto_err (proto_err)
    );

    typedef struct { logic [1:0] cntl; logic [63:0] data; } beat_t;
    typedef struct {
        logic [1:0] cntl; logic [63:0] data; logic [1:0] typ; logic [31:0] oob;
        logic [1:0] id; int cyc;
    } rx_t;
    typedef struct {
        int ch; logic [1:0] cntl; logic [63:0] data; logic exp_out; logic [3:0] exp_err;
    } vec_t;

    beat_t txq [NUM_MGR][$];
    rx_t   rxq [$];
    int    acc_cnt [NUM_MGR];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    logic [NUM_MGR-1:0] bfm_acc;

    function automatic logic [1:0] typ_of(logic [63:0] d);
        return d[1:0] ^ 2'b10;
    endfunction

    function automatic logic [31:0] oob_of(logic [63:0] d);
        return d[31:0] ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs are stable from posedge+1 through the next edge; transfers are judged at negedge.
    always begin
        @(negedge clk);
        bfm_acc = mgr_valid & ready;
        if (stu_valid && stu_ready)
            rxq.push_back('{cntl: stu_cntl, data: stu_data, typ: stu_type,
                            oob: stu_oob, id: stu_id, cyc: cyc});
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_MGR; i++) begin
            if (bfm_acc[i] && txq[i].size() > 0) begin
                void'(txq[i].pop_front());
                acc_cnt[i]++;
            end
            if (txq[i].size() > 0) begin
                mgr_valid[i]              = 1'b1;
                mgr_cntl[2*i +: 2]        = txq[i][0].cntl;
                mgr_data[DATA_W*i +: DATA_W] = txq[i][0].data;
                mgr_type[TYPE_W*i +: TYPE_W] = typ_of(txq[i][0].data);
                mgr_oob[OOB_W*i +: OOB_W]    = oob_of(txq[i][0].data);
            end else begin
                mgr_valid[i] = 1'b0;
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(int ch, logic [1:0] c, logic [63:0] d);
        txq[ch].push_back('{cntl: c, data: d});
    endtask

    task automatic do_reset();
        reset_poweron = 1'b1;
        for (int i = 0; i < NUM_MGR; i++) txq[i].delete();
        step(2);
        reset_poweron = 1'b0;
        step(1);
        rxq.delete();
        for (int i = 0; i < NUM_MGR; i++) acc_cnt[i] = 0;
    endtask

    task automatic wait_rx(int n, int budget, string name);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(name, 64'(rxq.size() >= n), 64'd1);
    endtask

    task automatic check_rx(int k, logic [1:0] c, logic [63:0] d, logic [1:0] id, string tag);
        if (rxq.size() > k) begin
            check($sformatf("%s[%0d].cntl", tag, k), 64'(rxq[k].cntl), 64'(c));
            check($sformatf("%s[%0d].data", tag, k), rxq[k].data, d);
            check($sformatf("%s[%0d].id",   tag, k), 64'(rxq[k].id), 64'(id));
        end else begin
            check($sformatf("%s[%0d].missing", tag, k), 64'(rxq.size()), 64'(k + 1));
        end
    endtask

    vec_t vecs [6];
    logic [63:0] exp_d [12];
    logic [1:0]  exp_c [12];
    logic [1:0]  exp_i [12];
    int          t0;
    int          unstable;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_poweron = 1'b1;
        stu_ready     = 1'b1;
        for (int i = 0; i < NUM_MGR; i++) acc_cnt[i] = 0;

        vecs[0] = '{2, SOE, 64'h0000_0000_0000_00A5, 1'b1, 4'b0000};
        vecs[1] = '{0, SOE, 64'h0123_4567_89AB_CDEF, 1'b1, 4'b0000};
        vecs[2] = '{3, SOE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b0000};
        vecs[3] = '{0, MOM, 64'h0000_0000_0000_DEAD, 1'b0, 4'b0001};
        vecs[4] = '{3, EOM, 64'h0000_0000_0000_BEEF, 1'b0, 4'b1001};
        vecs[5] = '{1, SOE, 64'h0000_0000_0000_0000, 1'b1, 4'b1001};

        do_reset();
        check("rst.valid", 64'(stu_valid), 64'd0);
        check("rst.cntl",  64'(stu_cntl),  64'd0);
        check("rst.type",  64'(stu_type),  64'd0);
        check("rst.data",  stu_data,       64'd0);
        check("rst.oob",   64'(stu_oob),   64'd0);
        check("rst.id",    64'(stu_id),    64'd0);
        check("rst.err",   64'(proto_err), 64'd0);
        check("rst.ready", 64'(ready),     64'hF);

        // Single beats and stray heads; beat presented at cyc t0+1, visible two cycles later.
        for (int v = 0; v < 6; v++) begin
            rxq.delete();
            t0 = cyc;
            send(vecs[v].ch, vecs[v].cntl, vecs[v].data);
            step(6);
            check($sformatf("v%0d.rx_cnt", v), 64'(rxq.size()), 64'(vecs[v].exp_out));
            if (vecs[v].exp_out && rxq.size() == 1) begin
                check($sformatf("v%0d.cntl", v), 64'(rxq[0].cntl), 64'(SOE));
                check($sformatf("v%0d.data", v), rxq[0].data, vecs[v].data);
                check($sformatf("v%0d.id", v),   64'(rxq[0].id), 64'(vecs[v].ch));
                check($sformatf("v%0d.type", v), 64'(rxq[0].typ), 64'(typ_of(vecs[v].data)));
                check($sformatf("v%0d.oob", v),  64'(rxq[0].oob), 64'(oob_of(vecs[v].data)));
                check($sformatf("v%0d.latency", v), 64'(rxq[0].cyc - t0), 64'd3);
            end
            check($sformatf("v%0d.err", v),   64'(proto_err), 64'(vecs[v].exp_err));
            check($sformatf("v%0d.ready", v), 64'(ready), 64'hF);
        end

        // Fair interleave: two 3-beat packets each from ch0 and ch3.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int ch = 0; ch < 4; ch += 3)
                for (int b = 0; b < 3; b++)
                    send(ch, (b == 0) ? SOM : ((b == 2) ? EOM : MOM), 64'(ch * 256 + p * 16 + b));
        for (int pk = 0; pk < 4; pk++)
            for (int b = 0; b < 3; b++) begin
                exp_i[pk*3+b] = (pk % 2 == 0) ? 2'd0 : 2'd3;
                exp_d[pk*3+b] = 64'(int'(exp_i[pk*3+b]) * 256 + (pk / 2) * 16 + b);
                exp_c[pk*3+b] = (b == 0) ? SOM : ((b == 2) ? EOM : MOM);
            end
        wait_rx(12, 100, "fair.timeout");
        step(4);
        check("fair.rx_cnt", 64'(rxq.size()), 64'd12);
        for (int k = 0; k < 12; k++) check_rx(k, exp_c[k], exp_d[k], exp_i[k], "fair");
        check("fair.err", 64'(proto_err), 64'd0);

        // Backpressure: 8-beat packet on ch1 with downstream stalled.
        do_reset();
        stu_ready = 1'b0;
        for (int b = 0; b < 8; b++)
            send(1, (b == 0) ? SOM : ((b == 7) ? EOM : MOM), 64'h100 + 64'(b));
        step(3);
        unstable = 0;
        for (int k = 0; k < 7; k++) begin
            if (stu_valid !== 1'b1 || stu_data !== 64'h100 || stu_cntl !== SOM ||
                stu_id !== 2'd1 || stu_oob !== oob_of(64'h100))
                unstable++;
            step(1);
        end
        check("bp.hold_stable", 64'(unstable), 64'd0);
        check("bp.accepted", 64'(acc_cnt[1]), 64'd5);
        check("bp.ready", 64'(ready), 64'b1101);
        stu_ready = 1'b1;
        wait_rx(8, 60, "bp.timeout");
        check("bp.accepted_all", 64'(acc_cnt[1]), 64'd8);
        for (int b = 0; b < 8; b++)
            check_rx(b, (b == 0) ? SOM : ((b == 7) ? EOM : MOM), 64'h100 + 64'(b), 2'd1, "bp");

        // Protocol errors: stray MOM on ch0, SOM-SOM on ch1.
        do_reset();
        send(0, MOM, 64'h77);
        send(1, SOM, 64'h200);
        send(1, SOM, 64'h201);
        step(8);
        check("pe.rx_cnt", 64'(rxq.size()), 64'd2);
        check_rx(0, SOM, 64'h200, 2'd1, "pe");
        check_rx(1, EOM, 64'h201, 2'd1, "pe");
        check("pe.err", 64'(proto_err), 64'b0011);

        // Reset in the middle of a 4-beat ch3 packet.
        rxq.delete();
        for (int b = 0; b < 4; b++)
            send(3, (b == 0) ? SOM : ((b == 3) ? EOM : MOM), 64'h300 + 64'(b));
        t0 = 0;
        while (acc_cnt[3] < 1 && t0 < 20) begin
            step(1);
            t0++;
        end
        check("mr.beat1_accepted", 64'(acc_cnt[3] >= 1), 64'd1);
        reset_poweron = 1'b1;
        txq[3].delete();
        step(1);
        check("mr.valid", 64'(stu_valid), 64'd0);
        check("mr.err",   64'(proto_err), 64'd0);
        check("mr.ready", 64'(ready),     64'hF);
        reset_poweron = 1'b0;
        step(1);
        check("mr.ready_after", 64'(ready), 64'hF);
        rxq.delete();
        send(0, SOE, 64'h400);
        wait_rx(1, 20, "mr.timeout");
        step(5);
        check("mr.rx_cnt", 64'(rxq.size()), 64'd1);
        check_rx(0, SOE, 64'h400, 2'd0, "mr");
        check("mr.err_after", 64'(proto_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
